fp_mult_sched: RTL and testbench

//  Shares one pipelined single-precision fp_mult instance between two requesters.

---
 rtl/fp_mult_sched.sv | 103 ++++++++++
 tb/tb_fp_mult_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fp_mult_sched.sv
// fp_mult_sched: round-robin scheduler sharing one pipelined fp_mult between two requesters
//  Ports: req{0,1}_valid/ready/a/b operand inputs, res{0,1}_valid/ready/y result FIFO heads,
//  mult_a/mult_b registered operands to fp_mult, mult_y product from fp_mult, busy activity flag.
module fp_mult_sched #(
   parameter int LAT        = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int PTR_W      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        res0_valid,
   input  logic        res0_ready,
   output logic [31:0] res0_y,
   output logic        res1_valid,
   input  logic        res1_ready,
   output logic [31:0] res1_y,
   output logic [31:0] mult_a,
   output logic [31:0] mult_b,
   input  logic [31:0] mult_y,
   output logic        busy
);
   localparam logic [PTR_W:0] DEPTH = (PTR_W+1)'(FIFO_DEPTH);
   logic [1:0] valid, rrdy, el, gnt, push, pop;
   logic [1:0][PTR_W:0] cnt_q, cnt_d, infl_q, infl_d;
   logic [1:0][PTR_W-1:0] wp_q, rp_q;
   logic [1:0][FIFO_DEPTH-1:0][31:0] mem_q;
   logic [LAT-1:0] tv_q, tv_d, tid_q, tid_d;
   logic prio1_q, prio1_d;
   logic [31:0] a_q, b_q;
   assign valid = {req1_valid, req0_valid};
   assign rrdy  = {res1_ready, res0_ready};
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         // queued plus in-flight results must fit in the FIFO, so a push can never overflow
         el[k]   = valid[k] && (cnt_q[k] + infl_q[k] < DEPTH);
         push[k] = tv_q[LAT-1] && (tid_q[LAT-1] == 1'(k));
         pop[k]  = (cnt_q[k] != '0) && rrdy[k];
      end
      // prio1_q set means req1 wins a tie
      gnt[0] = el[0] && (!el[1] || !prio1_q);
      gnt[1] = el[1] && (!el[0] || prio1_q);
      for (int k = 0; k < 2; k++) begin
         cnt_d[k]  = cnt_q[k] + (PTR_W+1)'(push[k]) - (PTR_W+1)'(pop[k]);
         infl_d[k] = infl_q[k] + (PTR_W+1)'(gnt[k]) - (PTR_W+1)'(push[k]);
      end
      prio1_d = gnt[0] ? 1'b1 : gnt[1] ? 1'b0 : prio1_q;
      tv_d[0]  = |gnt;
      tid_d[0] = gnt[1];
      for (int i = 1; i < LAT; i++) begin
         tv_d[i]  = tv_q[i-1];
         tid_d[i] = tid_q[i-1];
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         infl_q  <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         tv_q    <= '0;
         tid_q   <= '0;
         prio1_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         cnt_q   <= cnt_d;
         infl_q  <= infl_d;
         tv_q    <= tv_d;
         tid_q   <= tid_d;
         prio1_q <= prio1_d;
         for (int k = 0; k < 2; k++) begin
            if (push[k]) wp_q[k] <= wp_q[k] + 1'b1;
            if (pop[k]) rp_q[k] <= rp_q[k] + 1'b1;
         end
         if (|gnt) begin
            a_q <= gnt[1] ? req1_a : req0_a;
            b_q <= gnt[1] ? req1_b : req0_b;
         end
      end
   end
   always_ff @(posedge clk) begin
      for (int k = 0; k < 2; k++)
         if (push[k]) mem_q[k][wp_q[k]] <= mult_y;
   end
   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];
   assign res0_valid = cnt_q[0] != '0;
   assign res1_valid = cnt_q[1] != '0;
   // storage is not reset, so the head is masked while the FIFO is empty
   assign res0_y = res0_valid ? mem_q[0][rp_q[0]] : '0;
   assign res1_y = res1_valid ? mem_q[1][rp_q[1]] : '0;
   assign mult_a = a_q;
   assign mult_b = b_q;
   assign busy   = |tv_q | res0_valid | res1_valid;
endmodule

// File: tb/tb_fp_mult_sched.sv
// tb_fp_mult_sched: randomized checks of fp_mult_sched against a queue-based reference model
module tb_fp_mult_sched;
   localparam int LAT = 3;
   logic clk, rst;
   logic req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic res0_valid, res0_ready, res1_valid, res1_ready;
   logic [31:0] res0_y, res1_y, mult_a, mult_b, mult_y;
   logic busy;
   logic [31:0] p1, p2;
   typedef struct { logic [31:0] v; int t; } ent_t;
   ent_t q0[$], q1[$];
   int cyc = 0, checks = 0, errors = 0;
   logic last1;
   logic [31:0] ea, eb;
   localparam logic [31:0] Z = 32'h0;

   fp_mult_sched #(.LAT(LAT), .FIFO_DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_y(res0_y),
      .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_y(res1_y),
      .mult_a(mult_a), .mult_b(mult_b), .mult_y(mult_y), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // normal-number single-precision multiply, truncating; stands in for fp_mult
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [9:0] e;
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0;
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127 + 10'(p[47]);
      return {a[31] ^ b[31], e[7:0], p[47] ? p[46:24] : p[45:23]};
   endfunction

   function automatic logic [31:0] rnd_f();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
   endfunction

   // LAT-stage fp_mult: two registers after the scheduler's own operand register
   always @(posedge clk) begin
      p1 <= fmul(mult_a, mult_b);
      p2 <= p1;
   end
   assign mult_y = p2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic r0, input logic r1);
      logic el0, el1, g0, g1, rv0, rv1;
      @(posedge clk);
      #1;
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
      res0_ready = r0; res1_ready = r1;
      @(negedge clk);
      cyc++;
      el0 = v0 && q0.size() < 4;
      el1 = v1 && q1.size() < 4;
      g0  = el0 && (!el1 || last1);
      g1  = el1 && (!el0 || !last1);
      rv0 = q0.size() > 0 && q0[0].t <= cyc;
      rv1 = q1.size() > 0 && q1[0].t <= cyc;
      chk("req0_ready", 32'(req0_ready), 32'(g0));
      chk("req1_ready", 32'(req1_ready), 32'(g1));
      chk("res0_valid", 32'(res0_valid), 32'(rv0));
      chk("res1_valid", 32'(res1_valid), 32'(rv1));
      if (rv0) chk("res0_y", res0_y, q0[0].v);
      if (rv1) chk("res1_y", res1_y, q1[0].v);
      chk("busy", 32'(busy), 32'(q0.size() + q1.size() > 0));
      chk("mult_a", mult_a, ea);
      chk("mult_b", mult_b, eb);
      if (rv0 && r0) void'(q0.pop_front());
      if (rv1 && r1) void'(q1.pop_front());
      if (g0) begin
         q0.push_back('{fmul(a0, b0), cyc + LAT + 1});
         last1 = 1'b0; ea = a0; eb = b0;
      end
      if (g1) begin
         q1.push_back('{fmul(a1, b1), cyc + LAT + 1});
         last1 = 1'b1; ea = a1; eb = b1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 req0_valid = 1'b0; req1_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("rst_res0_valid", 32'(res0_valid), Z);
      chk("rst_res1_valid", 32'(res1_valid), Z);
      chk("rst_res0_y", res0_y, Z);
      chk("rst_res1_y", res1_y, Z);
      chk("rst_mult_a", mult_a, Z);
      chk("rst_mult_b", mult_b, Z);
      chk("rst_busy", 32'(busy), Z);
      chk("rst_req0_ready", 32'(req0_ready), Z);
      chk("rst_req1_ready", 32'(req1_ready), Z);
      q0.delete(); q1.delete();
      last1 = 1'b1; ea = Z; eb = Z;
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      {req0_valid, req1_valid, res0_ready, res1_ready} = '0;
      {req0_a, req0_b, req1_a, req1_b} = '0;
      do_reset();
      step(1'b1, 32'h40000000, 32'h40400000, 1'b0, Z, Z, 1'b1, 1'b1);
      repeat (6) step(1'b0, Z, Z, 1'b0, Z, Z, 1'b1, 1'b1);
      repeat (30) step(1'b1, rnd_f(), rnd_f(), 1'b1, rnd_f(), rnd_f(), 1'b1, 1'b1);
      repeat (20) step(1'b0, Z, Z, 1'b1, rnd_f(), rnd_f(), 1'b1, 1'b1);
      repeat (12) step(1'b1, rnd_f(), rnd_f(), 1'b1, rnd_f(), rnd_f(), 1'b1, 1'b0);
      repeat (12) step(1'b1, rnd_f(), rnd_f(), 1'b1, rnd_f(), rnd_f(), 1'b1, 1'b1);
      repeat (10) step(1'b1, rnd_f(), rnd_f(), 1'b0, Z, Z, 1'b0, 1'b1);
      repeat (24) step(1'b1, rnd_f(), rnd_f(), 1'b0, Z, Z, 1'($urandom_range(0, 1)), 1'b1);
      repeat (400)
         step(1'($urandom_range(0, 9) < 7), rnd_f(), rnd_f(),
              1'($urandom_range(0, 9) < 7), rnd_f(), rnd_f(),
              1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 6));
      repeat (12) step(1'b0, Z, Z, 1'b0, Z, Z, 1'b1, 1'b1);
      repeat (2) step(1'b1, rnd_f(), rnd_f(), 1'b0, Z, Z, 1'b0, 1'b0);
      repeat (3) step(1'b0, Z, Z, 1'b1, rnd_f(), rnd_f(), 1'b0, 1'b0);
      do_reset();
      repeat (10) step(1'b0, Z, Z, 1'b0, Z, Z, 1'b1, 1'b1);
      step(1'b1, rnd_f(), rnd_f(), 1'b1, rnd_f(), rnd_f(), 1'b1, 1'b1);
      repeat (40)
         step(1'($urandom_range(0, 1)), rnd_f(), rnd_f(),
              1'($urandom_range(0, 1)), rnd_f(), rnd_f(), 1'b1, 1'b1);
      repeat (10) step(1'b0, Z, Z, 1'b0, Z, Z, 1'b1, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
